// File: rtl/test_status_monitor.sv
// ---------------------------------------------------------------------------
// test_status_monitor
//   End-of-test monitor for riscv-tests programs. It snoops the register-file
//   write-back port and shadows x3 (test number) and x27 (pass flag). A write
//   of 1 to x26 (done flag) starts a settle period. When that period ends, the
//   block latches a sticky pass/fail verdict. A RUN-state cycle limit can force
//   a timeout verdict instead.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous reset, active low
//   wb_en         in   register-file write enable
//   wb_addr       in   destination register index [4:0]
//   wb_data       in   write data [XLEN-1:0]
//   done          out  verdict valid, sticky until reset
//   pass          out  1 = test passed (meaningful while done=1)
//   timeout       out  1 = verdict produced by the cycle limit
//   fail_testnum  out  x3 value at a fail verdict, else 0
//   cycle_count   out  cycles spent in RUN+SETTLE, saturating
// ---------------------------------------------------------------------------
module test_status_monitor #(
    parameter int XLEN           = 64,
    parameter int SETTLE_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_RUN, S_SETTLE, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [XLEN-1:0]  x3_q, x3_d;
    logic [XLEN-1:0]  x27_q, x27_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             timeout_q, timeout_d;
    logic [XLEN-1:0]  fail_q, fail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The trigger comes straight from the bus write. No x26 shadow is needed,
    // because only the write that sets x26 to 1 matters.
    logic trig;
    assign trig = wb_en && (wb_addr == 5'd26) && (wb_data == XLEN'(1));

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        x3_d      = x3_q;
        x27_d     = x27_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        fail_d    = fail_q;
        cnt_d     = cnt_q;

        // Shadows and the cycle counter are frozen once a verdict exists.
        if (state_q != S_DONE) begin
            if (wb_en && wb_addr == 5'd3)  x3_d  = wb_data;
            if (wb_en && wb_addr == 5'd27) x27_d = wb_data;
            if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_RUN: begin
                // The trigger takes priority over a timeout on the same edge.
                if (trig) begin
                    state_d  = S_SETTLE;
                    settle_d = SW'(SETTLE_CYCLES);
                end else if (TIMEOUT_CYCLES != 0 &&
                             cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                    fail_d    = x3_q;
                end
            end
            S_SETTLE: begin
                // The verdict uses shadow contents from before this edge.
                // Any x27 write on the verdict edge comes too late.
                if (settle_q == '0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    pass_d    = (x27_q == XLEN'(1));
                    fail_d    = (x27_q == XLEN'(1)) ? '0 : x3_q;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_RUN;
            settle_q  <= '0;
            x3_q      <= '0;
            x27_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            fail_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            x3_q      <= x3_d;
            x27_q     <= x27_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            fail_q    <= fail_d;
            cnt_q     <= cnt_d;
        end
    end

    assign done         = done_q;
    assign pass         = pass_q;
    assign timeout      = timeout_q;
    assign fail_testnum = fail_q;
    assign cycle_count  = cnt_q;

endmodule

// File: tb/tb_test_status_monitor.sv
// ---------------------------------------------------------------------------
// tb_test_status_monitor
//   Directed bench with two monitor instances on one shared write-back bus.
//     dut_a: SETTLE_CYCLES=100, default timeout (pass, fail, late x27,
//            spurious x26 write, reset mid-SETTLE and in DONE)
//     dut_b: SETTLE_CYCLES=3, TIMEOUT_CYCLES=50 (timeout, trigger/timeout
//            collision, x0/x31 writes)
//   The instance not under test is held in reset. Inputs change on the
//   falling edge, so each falling edge follows exactly one sampled rising edge.
// ---------------------------------------------------------------------------
module tb_test_status_monitor;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    logic        done_a, pass_a, to_a;
    logic [63:0] fail_a;
    logic [31:0] cnt_a;
    logic        done_b, pass_b, to_b;
    logic [63:0] fail_b;
    logic [31:0] cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    test_status_monitor #(.XLEN(64), .SETTLE_CYCLES(100), .TIMEOUT_CYCLES(1000000), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .done(done_a), .pass(pass_a), .timeout(to_a), .fail_testnum(fail_a), .cycle_count(cnt_a)
    );

    test_status_monitor #(.XLEN(64), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(50), .CNT_W(32)) dut_b (
        .clk(clk), .rst(rst_b), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .done(done_b), .pass(pass_b), .timeout(to_b), .fail_testnum(fail_b), .cycle_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One write, sampled on the next rising edge. Returns on the falling edge
    // after that rising edge.
    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        @(negedge clk);
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic start_a();
        rst_b = 1'b0; rst_a = 1'b0;
        idle(2);
        rst_a = 1'b1;
    endtask

    task automatic start_b();
        rst_a = 1'b0; rst_b = 1'b0;
        idle(2);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        idle(3);
        chk("rst_done",    64'(done_a), 64'd0);
        chk("rst_pass",    64'(pass_a), 64'd0);
        chk("rst_timeout", 64'(to_a),   64'd0);
        chk("rst_fail",    fail_a,      64'd0);
        chk("rst_cnt",     64'(cnt_a),  64'd0);

        // Pass: x3=5, x27=1, x26=1 at E0 (third edge after release).
        start_a();
        wr(5'd3, 64'd5); wr(5'd27, 64'd1); wr(5'd26, 64'd1);
        idle(100);
        chk("pass_done_early", 64'(done_a), 64'd0);
        idle(1);
        chk("pass_done",    64'(done_a), 64'd1);
        chk("pass_pass",    64'(pass_a), 64'd1);
        chk("pass_timeout", 64'(to_a),   64'd0);
        chk("pass_fail",    fail_a,      64'd0);
        chk("pass_cnt",     64'(cnt_a),  64'd104);
        wr(5'd27, 64'd0); idle(4);
        chk("pass_sticky",  64'(pass_a), 64'd1);
        chk("pass_cnt_hold", 64'(cnt_a), 64'd104);

        // Spurious x26=2, then fail with x3=0x17.
        start_a();
        wr(5'd3, 64'h17); wr(5'd27, 64'd0);
        wr(5'd26, 64'd2); wr(5'd26, 64'h1_0000_0001);
        idle(110);
        chk("x26_2_no_trig", 64'(done_a), 64'd0);
        wr(5'd26, 64'd1);
        idle(101);
        chk("fail_done", 64'(done_a), 64'd1);
        chk("fail_pass", 64'(pass_a), 64'd0);
        chk("fail_num",  fail_a,      64'h17);

        // x27 written at E0+100: still counted.
        start_a();
        wr(5'd3, 64'd7); wr(5'd27, 64'd0); wr(5'd26, 64'd1);
        idle(99);
        wr(5'd27, 64'd1);
        idle(1);
        chk("late100_done", 64'(done_a), 64'd1);
        chk("late100_pass", 64'(pass_a), 64'd1);

        // x27 written at E0+101: too late.
        start_a();
        wr(5'd3, 64'd7); wr(5'd27, 64'd0); wr(5'd26, 64'd1);
        idle(100);
        wr(5'd27, 64'd1);
        chk("late101_done", 64'(done_a), 64'd1);
        chk("late101_pass", 64'(pass_a), 64'd0);
        chk("late101_num",  fail_a,      64'd7);
        wr(5'd3, 64'd99); idle(3);
        chk("late101_frozen_pass", 64'(pass_a), 64'd0);
        chk("late101_frozen_num",  fail_a,      64'd7);

        // Reset mid-SETTLE, then a fresh trigger with normal timing.
        start_a();
        wr(5'd3, 64'd4); wr(5'd27, 64'd1); wr(5'd26, 64'd1);
        idle(50);
        rst_a = 1'b0; idle(1); rst_a = 1'b1;
        chk("midrst_done", 64'(done_a), 64'd0);
        chk("midrst_cnt",  64'(cnt_a),  64'd0);
        wr(5'd3, 64'd4); wr(5'd27, 64'd1); wr(5'd26, 64'd1);
        idle(100);
        chk("midrst_early", 64'(done_a), 64'd0);
        idle(1);
        chk("midrst_done2", 64'(done_a), 64'd1);
        chk("midrst_pass2", 64'(pass_a), 64'd1);
        chk("midrst_cnt2",  64'(cnt_a),  64'd104);
        rst_a = 1'b0; idle(1); rst_a = 1'b1;
        chk("donerst_done", 64'(done_a), 64'd0);
        chk("donerst_pass", 64'(pass_a), 64'd0);
        chk("donerst_cnt",  64'(cnt_a),  64'd0);

        // Timeout: no trigger, x3=9, limit 50.
        start_b();
        wr(5'd3, 64'd9);
        idle(48);
        chk("to_early_done", 64'(done_b), 64'd0);
        chk("to_early_cnt",  64'(cnt_b),  64'd49);
        idle(1);
        chk("to_done",    64'(done_b), 64'd1);
        chk("to_timeout", 64'(to_b),   64'd1);
        chk("to_pass",    64'(pass_b), 64'd0);
        chk("to_num",     fail_b,      64'd9);
        chk("to_cnt",     64'(cnt_b),  64'd50);
        idle(5);
        chk("to_cnt_hold", 64'(cnt_b), 64'd50);

        // Trigger on the same edge the timeout would fire (cycle_count=49).
        start_b();
        wr(5'd3, 64'd9); wr(5'd27, 64'd1);
        idle(47);
        chk("coll_cnt_pre", 64'(cnt_b), 64'd49);
        wr(5'd26, 64'd1);
        chk("coll_no_done", 64'(done_b), 64'd0);
        chk("coll_no_to",   64'(to_b),   64'd0);
        idle(3);
        chk("coll_early", 64'(done_b), 64'd0);
        idle(1);
        chk("coll_done", 64'(done_b), 64'd1);
        chk("coll_to",   64'(to_b),   64'd0);
        chk("coll_pass", 64'(pass_b), 64'd1);
        chk("coll_cnt",  64'(cnt_b),  64'd54);

        // Writes to x0 and x31 must not touch the x3/x27 shadows.
        start_b();
        wr(5'd3, 64'h11); wr(5'd27, 64'd0);
        wr(5'd0, 64'd1); wr(5'd31, 64'd1);
        wr(5'd0, 64'h22); wr(5'd31, 64'h33);
        wr(5'd26, 64'd1);
        idle(4);
        chk("x0x31_done", 64'(done_b), 64'd1);
        chk("x0x31_pass", 64'(pass_b), 64'd0);
        chk("x0x31_num",  fail_b,      64'h11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
